// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: tracks in-flight destinations in E/M/W and derives stall and forwarding selects.
// Build option FWD_D_EN: enables D-stage forwarding with Tnew/Tuse-based stalling; otherwise D stalls on any in-flight match.
module hazard_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1D,
  input  logic [4:0] A2D,
  input  logic       UseRsD,
  input  logic       UseRtD,
  input  logic [1:0] TuseRsD,
  input  logic [1:0] TuseRtD,
  input  logic [4:0] A3D,
  input  logic [1:0] TnewD,
  output logic       Stall,
  output logic [1:0] FwdRsD,
  output logic [1:0] FwdRtD,
  output logic [1:0] FwdRsE,
  output logic [1:0] FwdRtE
);

  logic [4:0] r_a1e, r_a2e, r_a3e, r_a3m, r_a3w;
  logic [1:0] r_tnewe, r_tnewm;

  // Reset outranks Stall so a pending stalled instruction leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a1e   <= 5'd0;
      r_a2e   <= 5'd0;
      r_a3e   <= 5'd0;
      r_tnewe <= 2'd0;
      r_a3m   <= 5'd0;
      r_tnewm <= 2'd0;
      r_a3w   <= 5'd0;
    end else begin
      r_a1e   <= Stall ? 5'd0 : A1D;
      r_a2e   <= Stall ? 5'd0 : A2D;
      r_a3e   <= Stall ? 5'd0 : A3D;
      r_tnewe <= Stall ? 2'd0 : TnewD;
      r_a3m   <= r_a3e;
      r_tnewm <= (r_tnewe == 2'd0) ? 2'd0 : r_tnewe - 2'd1;
      r_a3w   <= r_a3m;
    end
  end

  // A match against destination 0 is never a hazard.
  function automatic logic f_hit(input logic [4:0] a, input logic [4:0] dst);
    return (dst != 5'd0) && (a == dst);
  endfunction

  function automatic logic [1:0] f_fwd_e(input logic [4:0] a);
    if (f_hit(a, r_a3m) && r_tnewm == 2'd0) return 2'b01;
    else if (f_hit(a, r_a3w))               return 2'b10;
    else                                    return 2'b00;
  endfunction

  logic w_stall_rs, w_stall_rt;

`ifdef FWD_D_EN
  function automatic logic [1:0] f_fwd_d(input logic [4:0] a);
    if (f_hit(a, r_a3e) && r_tnewe == 2'd0)      return 2'b11;
    else if (f_hit(a, r_a3m) && r_tnewm == 2'd0) return 2'b01;
    else if (f_hit(a, r_a3w))                    return 2'b10;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    w_stall_rs = UseRsD && ((f_hit(A1D, r_a3e) && r_tnewe > TuseRsD) ||
                            (f_hit(A1D, r_a3m) && r_tnewm > TuseRsD));
    w_stall_rt = UseRtD && ((f_hit(A2D, r_a3e) && r_tnewe > TuseRtD) ||
                            (f_hit(A2D, r_a3m) && r_tnewm > TuseRtD));
    FwdRsD     = f_fwd_d(A1D);
    FwdRtD     = f_fwd_d(A2D);
  end
`else
  // Without D-stage forwarding the operand must come from the regfile, so wait out every producer.
  logic w_unused_tuse;
  assign w_unused_tuse = ^{TuseRsD, TuseRtD};

  always_comb begin
    w_stall_rs = UseRsD && (f_hit(A1D, r_a3e) || f_hit(A1D, r_a3m) || f_hit(A1D, r_a3w));
    w_stall_rt = UseRtD && (f_hit(A2D, r_a3e) || f_hit(A2D, r_a3m) || f_hit(A2D, r_a3w));
    FwdRsD     = 2'b00;
    FwdRtD     = 2'b00;
  end
`endif

  assign Stall  = w_stall_rs || w_stall_rt;
  assign FwdRsE = f_fwd_e(r_a1e);
  assign FwdRtE = f_fwd_e(r_a2e);

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker; expected values hand-derived per scenario.
module tb_hazard_tracker;

  logic       clk, reset;
  logic [4:0] A1D, A2D, A3D;
  logic       UseRsD, UseRtD;
  logic [1:0] TuseRsD, TuseRtD, TnewD;
  logic       Stall;
  logic [1:0] FwdRsD, FwdRtD, FwdRsE, FwdRtE;

  int n_vec = 0;
  int n_err = 0;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .A1D(A1D), .A2D(A2D), .UseRsD(UseRsD), .UseRtD(UseRtD),
    .TuseRsD(TuseRsD), .TuseRtD(TuseRtD), .A3D(A3D), .TnewD(TnewD),
    .Stall(Stall), .FwdRsD(FwdRsD), .FwdRtD(FwdRtD),
    .FwdRsE(FwdRsE), .FwdRtE(FwdRtE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                       input logic [1:0] t1, input logic [1:0] t2, input logic [4:0] a3, input logic [1:0] tn);
    A1D = a1; A2D = a2; UseRsD = u1; UseRtD = u2;
    TuseRsD = t1; TuseRtD = t2; A3D = a3; TnewD = tn;
    #2;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] all_fwd();
    return {FwdRsD, FwdRtD, FwdRsE, FwdRtE};
  endfunction

  initial begin
    reset = 1'b1;
    nop();
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("reset_stall", {7'd0, Stall}, 8'd0);
    chk("reset_fwd", all_fwd(), 8'h00);

    // ori $0 then addu reading $0: nothing matches
    do_reset();
    set_d(3, 0, 1, 0, 1, 1, 0, 1);
    chk("r0_ori_stall", {7'd0, Stall}, 8'd0);
    tick();
    set_d(0, 0, 1, 1, 1, 1, 2, 1);
    chk("r0_use_stall", {7'd0, Stall}, 8'd0);
    chk("r0_use_fwd", all_fwd(), 8'h00);
    tick();
    nop();
    chk("r0_e_fwd", all_fwd(), 8'h00);

    // E-stage forwarding: M beats W, then W-only, then Tnew pending
    do_reset();
    set_d(1, 2, 1, 1, 1, 1, 7, 1);
    tick();
    set_d(7, 7, 0, 0, 0, 0, 8, 1);
    chk("fe_nouse_stall", {7'd0, Stall}, 8'd0);
    tick();
    nop();
    chk("fe_m_fwd", {4'd0, FwdRsE, FwdRtE}, 8'b0101);
    tick();
    set_d(8, 7, 0, 0, 0, 0, 0, 0);
    chk("fe_bubble_fwd", {4'd0, FwdRsE, FwdRtE}, 8'b0000);
    tick();
    nop();
    chk("fe_w_fwd", {4'd0, FwdRsE, FwdRtE}, 8'b1000);

    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 9, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 9, 1);
    tick();
    set_d(9, 9, 0, 0, 0, 0, 0, 0);
    tick();
    nop();
    chk("fe_m_over_w", {4'd0, FwdRsE, FwdRtE}, 8'b0101);

    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 9, 2);
    tick();
    set_d(9, 9, 0, 0, 0, 0, 0, 0);
    tick();
    nop();
    chk("fe_lw_pending", {4'd0, FwdRsE, FwdRtE}, 8'b0000);

    // Reset during a stall discards the tracked producer
    do_reset();
    set_d(1, 2, 1, 1, 1, 1, 5, 1);
    tick();
    set_d(5, 0, 1, 1, 0, 0, 0, 0);
    chk("rst_pre_stall", {7'd0, Stall}, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("rst_post_stall", {7'd0, Stall}, 8'd0);
    chk("rst_post_fwd", all_fwd(), 8'h00);
    tick();
    #2;
    chk("rst_next_stall", {7'd0, Stall}, 8'd0);
    chk("rst_next_fwd", all_fwd(), 8'h00);

`ifdef FWD_D_EN
    // lw $1 ; addu $2,$1,$3
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 1, 2);
    chk("lu_lw_stall", {7'd0, Stall}, 8'd0);
    tick();
    set_d(1, 3, 1, 1, 1, 1, 2, 1);
    chk("lu_stall1", {7'd0, Stall}, 8'd1);
    tick();
    #2;
    chk("lu_stall_end", {7'd0, Stall}, 8'd0);
    tick();
    nop();
    chk("lu_fwdrse", {6'd0, FwdRsE}, 8'b10);

    // addu $4 ; beq $4,$0
    do_reset();
    set_d(1, 2, 1, 1, 1, 1, 4, 1);
    tick();
    set_d(4, 0, 1, 1, 0, 0, 0, 0);
    chk("br_stall1", {7'd0, Stall}, 8'd1);
    tick();
    #2;
    chk("br_stall_end", {7'd0, Stall}, 8'd0);
    chk("br_fwdrsd", {4'd0, FwdRsD, FwdRtD}, 8'b0100);

    // jal ; jr $31
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, 31, 0);
    tick();
    set_d(31, 0, 1, 0, 0, 0, 0, 0);
    chk("jr_stall", {7'd0, Stall}, 8'd0);
    chk("jr_fwdrsd", {6'd0, FwdRsD}, 8'b11);
`else
    // addu $5 ; subu $6,$5,$5 with no D forwarding: three stall cycles
    do_reset();
    set_d(1, 2, 1, 1, 1, 1, 5, 1);
    chk("nf_addu_stall", {7'd0, Stall}, 8'd0);
    tick();
    set_d(5, 5, 1, 1, 1, 1, 6, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("nf_stall%0d", i), {7'd0, Stall}, 8'd1);
      chk($sformatf("nf_fwdd%0d", i), {4'd0, FwdRsD, FwdRtD}, 8'b0000);
      tick();
      #2;
    end
    chk("nf_stall_end", {7'd0, Stall}, 8'd0);
    chk("nf_fwd_end", all_fwd(), 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: A1D, A2D  input  5 each  rs/rt register numbers of the instruction in D.
REQ-004 SHALL have ports: UseRsD, UseRtD  input  1 each  D instruction reads rs/rt.
REQ-005 SHALL have ports: TuseRsD, TuseRtD  input  2 each  cycles after D before rs/rt is needed (0 means needed in D).
REQ-006 SHALL have port: A3D  input  5  destination register of the D instruction; 0 means no write.
REQ-007 SHALL have port: TnewD  input  2  cycles after entering E before the result exists (lw 2, ALU 1, jal 0).
REQ-008 SHALL have port: Stall  output  1  freeze PC and F/D register; insert a bubble into E.
REQ-009 SHALL have ports: FwdRsD, FwdRtD  output  2 each  D operand source: 00 regfile, 01 M result, 10 W result, 11 E PC+8.
REQ-010 SHALL have ports: FwdRsE, FwdRtE  output  2 each  E operand source: 00 pipeline register, 01 M result, 10 W result.

Function
REQ-011 SHALL hold three tracking slots: E {A1E, A2E, A3E, TnewE}, M {A3M, TnewM}, W {A3W}.
REQ-012 SHALL, on each edge with Stall=0, load the E slot from A1D, A2D, A3D and TnewD.
REQ-013 SHALL, on each edge with Stall=1, load the E slot with a bubble: all fields 0.
REQ-014 SHALL, on every edge regardless of Stall, set M <= E with TnewM = saturating TnewE-1 (floor 0), and set W <= M.
REQ-015 SHALL treat a register match as valid only when the destination field is nonzero; register 0 never stalls and never forwards.
REQ-016 SHALL assert Stall when UseRsD is set and A1D matches A3E with TnewE>TuseRsD, or matches A3M with TnewM>TuseRsD; rt is handled identically. Both terms are ORed.
REQ-017 SHALL derive Stall, FwdRsD/RtD and FwdRsE/RtE combinationally from the slots and the D inputs, with zero latency.
REQ-018 SHALL set the FwdRsD priority as: E match with TnewE=0 gives 11; else M match with TnewM=0 gives 01; else W match gives 10; else 00. FwdRtD follows the same rule.
REQ-019 SHALL set the FwdRsE priority as: A1E matches A3M with TnewM=0 gives 01; else A1E matches A3W gives 10; else 00. FwdRtE follows the same rule using A2E.
REQ-020 SHALL, when the D instruction writes the same register it reads, evaluate the hazard only against older slots, never against itself.
REQ-021 SHALL, under back-to-back stalls, keep inserting bubbles; the stalled D instruction stays in D until Stall deasserts.

Reset
REQ-022 SHALL, on reset, clear every slot field to 0; on the following cycle Stall=0 and all Fwd outputs are 00.
REQ-023 SHALL give reset priority over Stall; a reset mid-stall discards the pending instruction's tracking.

Configuration
REQ-024 SHALL support macro FWD_D_EN. When defined, REQ-016 and REQ-018 apply as written.
REQ-025 SHALL, when FWD_D_EN is not defined, tie FwdRsD and FwdRtD to 00, and assert Stall on any valid match of a used source against A3E, A3M or A3W, regardless of Tnew. The E-stage forwarding in REQ-019 is unaffected.

Verification
REQ-026 SHALL cover load-use: lw $1 (TnewD=2) then addu $2,$1,$3 (TuseRs=1). Required: Stall=1 for exactly 1 cycle; addu then enters E with FwdRsE=10.
REQ-027 SHALL cover ALU-to-branch: addu $4 (TnewD=1) then beq $4,$0 (TuseRs=0). Required: Stall=1 for 1 cycle, then FwdRsD=01.
REQ-028 SHALL cover jal then jr $31 (TuseRs=0). Required: Stall=0 and FwdRsD=11 in the cycle jal occupies E.
REQ-029 SHALL cover a register-0 write: ori $0 then addu using $0. Required: Stall=0 and all Fwd outputs 00.
REQ-030 SHALL cover reset asserted during a stall cycle. Required: next cycle, all slots 0, Stall=0 and all Fwd outputs 00.
REQ-031 SHALL cover a build without FWD_D_EN: addu $5 then subu $6,$5,$5. Required: Stall=1 for 3 cycles and FwdRsD=00 throughout.
